// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin with a bounded port-1 lock burst,
// a single issue register driving memory and a registered per-port response.
module dmem_arbiter #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ip_p0_req,
    input  logic        ip_p0_wr,
    input  logic [31:0] ip_p0_addr,
    input  logic [3:0]  ip_p0_mask,
    input  logic [31:0] ip_p0_wdata,
    input  logic        ip_p1_req,
    input  logic        ip_p1_wr,
    input  logic [31:0] ip_p1_addr,
    input  logic [3:0]  ip_p1_mask,
    input  logic [31:0] ip_p1_wdata,
    input  logic        ip_p1_lock,
    output logic        op_p0_gnt,
    output logic        op_p1_gnt,
    output logic        op_p0_ack,
    output logic        op_p1_ack,
    output logic [31:0] op_p0_rdata,
    output logic [31:0] op_p1_rdata,
    output logic [31:0] op_dmem_addr,
    output logic        op_dmem_wr,
    output logic [3:0]  op_dmem_mask,
    output logic [31:0] op_dmem_wdata,
    output logic        op_dmem_rd,
    input  logic        ip_dmem_valid,
    input  logic [31:0] ip_dmem_rdata
);
    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

    logic        iss_valid, iss_wr, iss_port;
    logic [31:0] iss_addr, iss_wdata;
    logic [3:0]  iss_mask;
    logic        last_gnt;
    logic [7:0]  lock_cnt;
    logic        stall, lock_win;

    assign stall = iss_valid & ~iss_wr & ~ip_dmem_valid;
    // Lock only extends a burst already begun, so the first tie after a
    // port-0 grant or reset is still settled by round robin.
    assign lock_win = ip_p1_lock & last_gnt & (lock_cnt != 8'd0) & (lock_cnt < LOCK_MAX);

    always_comb begin
        op_p0_gnt = 1'b0;
        op_p1_gnt = 1'b0;
        if (!rst && !stall) begin
            if (ip_p0_req && ip_p1_req) begin
                if (lock_win || !last_gnt) op_p1_gnt = 1'b1;
                else                       op_p0_gnt = 1'b1;
            end else begin
                op_p0_gnt = ip_p0_req;
                op_p1_gnt = ip_p1_req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid   <= 1'b0;
            iss_wr      <= 1'b0;
            iss_port    <= 1'b0;
            iss_addr    <= '0;
            iss_mask    <= '0;
            iss_wdata   <= '0;
            last_gnt    <= 1'b1;
            lock_cnt    <= '0;
            op_p0_ack   <= 1'b0;
            op_p1_ack   <= 1'b0;
            op_p0_rdata <= '0;
            op_p1_rdata <= '0;
        end else begin
            if (!stall) begin
                iss_valid <= op_p0_gnt | op_p1_gnt;
                if (op_p0_gnt) begin
                    iss_wr    <= ip_p0_wr;
                    iss_addr  <= ip_p0_addr;
                    iss_mask  <= ip_p0_mask;
                    iss_wdata <= ip_p0_wdata;
                    iss_port  <= 1'b0;
                end else if (op_p1_gnt) begin
                    iss_wr    <= ip_p1_wr;
                    iss_addr  <= ip_p1_addr;
                    iss_mask  <= ip_p1_mask;
                    iss_wdata <= ip_p1_wdata;
                    iss_port  <= 1'b1;
                end
            end
            op_p0_ack <= iss_valid & ~stall & ~iss_port;
            op_p1_ack <= iss_valid & ~stall & iss_port;
            if (iss_valid && !iss_wr && ip_dmem_valid) begin
                if (iss_port) op_p1_rdata <= ip_dmem_rdata;
                else          op_p0_rdata <= ip_dmem_rdata;
            end
            if (op_p0_gnt || op_p1_gnt) last_gnt <= op_p1_gnt;
            if (!ip_p1_lock || op_p0_gnt)
                lock_cnt <= '0;
            else if (op_p1_gnt && lock_cnt < LOCK_MAX)
                lock_cnt <= lock_cnt + 8'd1;
        end
    end

    assign op_dmem_wr    = iss_valid & iss_wr;
    assign op_dmem_rd    = iss_valid & ~iss_wr;
    assign op_dmem_addr  = iss_addr;
    assign op_dmem_mask  = iss_wr ? iss_mask : 4'h0;
    assign op_dmem_wdata = iss_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed transactions feed a scoreboard queue that
// an independent monitor drains on every ack; memory is a small array model.
module tb_dmem_arbiter;
    logic        clk = 0, rst = 1;
    logic        p0_req = 0, p0_wr = 0, p1_req = 0, p1_wr = 0, p1_lock = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic [3:0]  p0_mask = 0, p1_mask = 0;
    logic        p0_gnt, p1_gnt, p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_wr, dmem_rd, dvalid = 1;
    logic [3:0]  dmem_mask;

    typedef struct { bit port; bit rd; logic [31:0] data; int cyc; } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0, cyc = 0;
    logic [31:0] mem [256];

    dmem_arbiter #(.MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .ip_p0_req(p0_req), .ip_p0_wr(p0_wr), .ip_p0_addr(p0_addr),
        .ip_p0_mask(p0_mask), .ip_p0_wdata(p0_wdata),
        .ip_p1_req(p1_req), .ip_p1_wr(p1_wr), .ip_p1_addr(p1_addr),
        .ip_p1_mask(p1_mask), .ip_p1_wdata(p1_wdata), .ip_p1_lock(p1_lock),
        .op_p0_gnt(p0_gnt), .op_p1_gnt(p1_gnt), .op_p0_ack(p0_ack), .op_p1_ack(p1_ack),
        .op_p0_rdata(p0_rdata), .op_p1_rdata(p1_rdata),
        .op_dmem_addr(dmem_addr), .op_dmem_wr(dmem_wr), .op_dmem_mask(dmem_mask),
        .op_dmem_wdata(dmem_wdata), .op_dmem_rd(dmem_rd),
        .ip_dmem_valid(dvalid), .ip_dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk)
        if (dmem_wr)
            for (int b = 0; b < 4; b++)
                if (dmem_mask[b]) mem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
    assign dmem_rdata = mem[dmem_addr[9:2]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (p0_ack || p1_ack)) begin
            total++;
            if (p0_ack && p1_ack) begin
                bad++; $display("FAIL dual_ack actual=11 required=one-hot");
            end else if (sb.size() == 0) begin
                bad++; $display("FAIL unexpected_ack actual=port%0d required=none", p1_ack);
            end else begin
                exp_t e;
                logic [31:0] rd;
                e = sb.pop_front();
                rd = p1_ack ? p1_rdata : p0_rdata;
                if (p1_ack != e.port || cyc != e.cyc || (e.rd && rd !== e.data)) begin
                    bad++;
                    $display("FAIL ack actual=port%0d cyc%0d data=%h required=port%0d cyc%0d data=%h",
                             p1_ack, cyc, rd, e.port, e.cyc, e.data);
                end
            end
        end
    end

    task automatic set_port(input bit port, input bit req, input bit wr,
                            input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wd);
        if (port) begin p1_req = req; p1_wr = wr; p1_addr = addr; p1_mask = mask; p1_wdata = wd; end
        else      begin p0_req = req; p0_wr = wr; p0_addr = addr; p0_mask = mask; p0_wdata = wd; end
    endtask

    task automatic txn(input bit port, input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] wd, input logic [31:0] exp, input int extra);
        bit got = 0;
        set_port(port, 1, wr, addr, mask, wd);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port ? p1_gnt : p0_gnt) got = 1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL gnt_timeout port=%0d actual=0 required=1", port); end
        else sb.push_back('{port, !wr, exp, cyc + 2 + extra});
        @(posedge clk); #1;
        set_port(port, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
    endtask

    // Both ports read continuously; pat[i] is the port expected to win cycle i.
    task automatic pattern(input string name, input bit lock, input int n, input logic [15:0] pat);
        do_reset();
        set_port(0, 1, 0, 32'h10, 4'h0, 0);
        set_port(1, 1, 0, 32'h20, 4'h0, 0);
        p1_lock = lock;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, {62'd0, p1_gnt, p0_gnt}, pat[i] ? 64'd2 : 64'd1);
            if (p0_gnt ^ p1_gnt)
                sb.push_back('{p1_gnt, 1'b1, p1_gnt ? 32'h1122AB44 : 32'hDEADBEEF, cyc + 2});
            @(posedge clk); #1;
        end
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        p1_lock = 0;
        drain();
    endtask

    initial begin
        // reset state, with a request already pending
        p0_req = 1;
        @(negedge clk);
        check("rst_gnt", {62'd0, p1_gnt, p0_gnt}, 64'd0);
        check("rst_dmem", {dmem_wr, dmem_rd, dmem_mask, 26'd0, dmem_addr}, 64'd0);
        check("rst_ack_rdata", {p0_ack, p1_ack, 30'd0, p0_rdata | p1_rdata | dmem_wdata}, 64'd0);
        p0_req = 0;
        @(posedge clk); #1 rst = 0;

        // write then read back-to-back, acks at N+2 and N+3
        txn(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0);
        txn(0, 0, 32'h10, 4'hF, 0, 32'hDEADBEEF, 0);
        drain();

        // partial-lane write merge, read from the other port
        txn(1, 1, 32'h20, 4'hF, 32'h11223344, 0, 0);
        txn(1, 1, 32'h20, 4'h2, 32'h0000AB00, 0, 0);
        txn(0, 0, 32'h20, 4'h0, 0, 32'h1122AB44, 0);
        drain();
        check("mem_merge", 64'(mem[8]), 64'h1122AB44);

        // memory not valid for three cycles on a port-1 read
        dvalid = 0;
        txn(1, 0, 32'h20, 4'h0, 0, 32'h1122AB44, 3);
        set_port(0, 1, 0, 32'h10, 4'h0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_gnt", {62'd0, p1_gnt, p0_gnt}, 64'd0);
            check("stall_hold", {dmem_rd, 31'd0, dmem_addr}, {1'b1, 31'd0, 32'h20});
            @(posedge clk); #1;
        end
        dvalid = 1;
        txn(0, 0, 32'h10, 4'h0, 0, 32'hDEADBEEF, 0);
        drain();

        pattern("rr_gnt", 0, 6, 16'b101010);
        pattern("lock_gnt", 1, 10, 16'b1111011110);

        // reset the cycle after a read accept: dropped, outputs cleared
        set_port(0, 1, 0, 32'h10, 4'h0, 0);
        @(negedge clk);
        check("pre_rst_gnt", 64'(p0_gnt), 64'd1);
        @(posedge clk); #1;
        set_port(0, 0, 0, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        check("midrst_dmem", {dmem_wr, dmem_rd, dmem_mask, 26'd0, dmem_addr}, 64'd0);
        check("midrst_ack_rdata", {p0_ack, p1_ack, 30'd0, p0_rdata | p1_rdata}, 64'd0);
        @(posedge clk); #1 rst = 0;
        set_port(0, 1, 0, 32'h10, 4'h0, 0);
        set_port(1, 1, 0, 32'h20, 4'h0, 0);
        @(negedge clk);
        check("post_rst_tie", {62'd0, p1_gnt, p0_gnt}, 64'd1);
        if (p0_gnt) sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF, cyc + 2});
        @(posedge clk); #1;
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
